cm82_slice_sched: RTL

//  Round-robin scheduler sharing one 1-bit sum/carry slice (sum = a^b^c, carry = maj(a,b,c))

---
 rtl/cm82_slice_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cm82_slice_sched.sv
// cm82_slice_sched: round-robin scheduler sharing one 1-bit sum/carry slice
// among NREQ requesters. Each granted W-bit add is executed bit-serially,
// LSB first, and the result is handed back with its requester id.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. A requester holds req_valid and its
// operands stable until it sees its req_ready pulse; it may drop req_valid
// before being granted, in which case it is simply not served. req_ready is a
// one-cycle one-hot pulse driven only in IDLE. On the response side rsp_valid
// and rsp_* stay stable until the cycle where rsp_ready is high; rsp_* keep
// the last result after that until the next result overwrites them.
module cm82_slice_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*W-1:0]  req_a,
  input  logic [NREQ*W-1:0]  req_b,
  input  logic [NREQ-1:0]    req_cin,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [W-1:0]       rsp_sum,
  output logic               rsp_cout,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit counter must hold 0..W-1; keep at least one bit for W=1.
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(W - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  cur_id;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W-1:0]    acc;
  logic [CW-1:0]   bit_cnt;
  logic            carry;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  next_ptr;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            sel_cin;

  logic            slice_a;
  logic            slice_b;
  logic            slice_sum;
  logic            slice_carry;
  logic [W-1:0]    next_acc;

  // Round-robin search: scan from the highest offset down so the valid
  // requester closest to rr_ptr (offset 0 first) is the one that sticks.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDW'((int'(rr_ptr) + i) % NREQ);
      if (req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Pointer moves one past the winner so it becomes lowest priority next time.
  always_comb begin
    next_ptr = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a   = req_a[grant_idx*W +: W];
    sel_b   = req_b[grant_idx*W +: W];
    sel_cin = req_cin[grant_idx];
  end

  // Accept pulse: only in IDLE, only to the winner, only for this cycle.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_found) begin
      req_ready = NREQ'(1) << grant_idx;
    end
  end

  // The shared compute slice: full adder on the current LSBs plus carry.
  always_comb begin
    slice_a     = op_a[0];
    slice_b     = op_b[0];
    slice_sum   = slice_a ^ slice_b ^ carry;
    slice_carry = (slice_a & slice_b) | (slice_a & carry) | (slice_b & carry);
  end

  // Partial result with this cycle's sum bit dropped into position bit_cnt.
  always_comb begin
    next_acc          = acc;
    next_acc[bit_cnt] = slice_sum;
  end

  // Status outputs derived straight from the state register.
  always_comb begin
    busy      = (state != S_IDLE);
    dbg_state = state;
  end

  // Main FSM: grant in IDLE, W serial bit steps in RUN, hand back in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      bit_cnt   <= '0;
      carry     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            op_a    <= sel_a;
            op_b    <= sel_b;
            carry   <= sel_cin;
            cur_id  <= grant_idx;
            rr_ptr  <= next_ptr;
            acc     <= '0;
            bit_cnt <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= slice_carry;
          acc   <= next_acc;
          if (bit_cnt == LAST_BIT) begin
            // Last bit: publish the finished result in the same edge.
            bit_cnt   <= '0;
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_sum   <= next_acc;
            rsp_cout  <= slice_carry;
            state     <= S_DONE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_DONE: begin
          // No grant in the handshake cycle; IDLE arbitrates one cycle later.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
